// File: rtl/trng_req_arbiter.sv
// Round-robin arbiter sharing one TRNG among P_NUM_REQ requesters; grant 1 cycle after req, response 1 cycle after trng_done.
// Holds rsp_valid/rsp_data until rsp_ready of the granted requester; TRNG_ARB_TIMEOUT_EN adds a WAIT-state timeout.
module trng_req_arbiter #(
  parameter int P_NUM_REQ = 4,
  parameter int P_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   Resetn,
  input  logic [P_NUM_REQ-1:0]   req,
  input  logic [2*P_NUM_REQ-1:0] req_op,
  output logic [P_NUM_REQ-1:0]   req_ack,
  output logic [P_NUM_REQ-1:0]   rsp_valid,
  input  logic [P_NUM_REQ-1:0]   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   trng_go,
  output logic [1:0]             trng_op,
  input  logic                   trng_done,
  input  logic [127:0]           trng_data,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [2:0]  rr_ptr;
  logic [2:0]  idx;
  logic [7:0]  req_pad;
  logic [7:0]  rdy_pad;
  logic [15:0] op_pad;
  logic [3:0]  cand;
  logic [2:0]  sel;
  logic [1:0]  sel_op;
  logic        found;
  logic [7:0]  sel_oh;
  logic [7:0]  idx_oh;
  logic [2:0]  next_ptr;

`ifdef TRNG_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(P_TIMEOUT - 1);
  logic [15:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Pad to the 8-requester maximum so every index below is a fixed 3-bit select.
  always_comb begin
    req_pad = '0;
    rdy_pad = '0;
    op_pad  = '0;
    req_pad[P_NUM_REQ-1:0]   = req;
    rdy_pad[P_NUM_REQ-1:0]   = rsp_ready;
    op_pad[2*P_NUM_REQ-1:0]  = req_op;
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(P_NUM_REQ)) cand = cand - 4'(P_NUM_REQ);
      if (!found && req_pad[cand[2:0]]) begin
        found = 1'b1;
        sel   = cand[2:0];
      end
    end
  end

  assign sel_op   = op_pad[{sel, 1'b0} +: 2];
  assign sel_oh   = 8'b1 << sel;
  assign idx_oh   = 8'b1 << idx;
  assign next_ptr = (idx == 3'(P_NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      idx       <= '0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      trng_go   <= 1'b0;
      trng_op   <= '0;
      busy      <= 1'b0;
`ifdef TRNG_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      req_ack <= '0;
      trng_go <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            idx     <= sel;
            trng_op <= sel_op;
            req_ack <= sel_oh[P_NUM_REQ-1:0];
            trng_go <= 1'b1;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
`ifdef TRNG_ARB_TIMEOUT_EN
          wait_cnt <= (state == S_ISSUE) ? 16'd0 : wait_cnt + 16'd1;
`endif
          // A done arriving in the ISSUE cycle itself skips WAIT.
          if (trng_done) begin
            rsp_data  <= trng_data;
            rsp_valid <= idx_oh[P_NUM_REQ-1:0];
            state     <= S_RESP;
`ifdef TRNG_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (state == S_WAIT && wait_cnt == TO_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= idx_oh[P_NUM_REQ-1:0];
            state     <= S_RESP;
`endif
          end else begin
            state <= S_WAIT;
          end
        end
        S_RESP: begin
          if (rdy_pad[idx]) begin
            rsp_valid <= '0;
            trng_op   <= '0;
            busy      <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= S_IDLE;
`ifdef TRNG_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
